spi_slave_param: RTL and testbench

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_shifter.sv | 32 +++
 rtl/spi_slave_param.sv | 155 +++++++++++++++
 tb/tb_spi_slave_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave.
package spi_slave_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CMD_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4,
    ST_TX_WAIT   = 3'd5,
    ST_TX_SHIFT  = 3'd6
  } state_e;

  // Command field carried in the top two bits of every received frame.
  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shifter.sv
// Bidirectional-use shift register: serial-in/parallel-out and parallel-in/serial-out.
module spi_shifter #(
  parameter int unsigned W         = 10,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         ser_in,
  input  logic [W-1:0] par_in,
  output logic [W-1:0] par_out,
  output logic         ser_out
);

  logic [W-1:0] q;

  // Parallel load has priority over shifting; direction follows bit order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= par_in;
    end else if (shift) begin
      q <= MSB_FIRST ? {q[W-2:0], ser_in} : {ser_in, q[W-1:1]};
    end
  end

  assign par_out = q;
  assign ser_out = MSB_FIRST ? q[W-1] : q[0];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave sampled on the system clock: command select, framed receive, buffered transmit.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(DATA_W - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               rd_addr_seen, rd_addr_seen_nxt;
  logic               sh_load, sh_shift, sh_ser_out;
  logic [FRAME_W-1:0] sh_par_in, sh_q, rx_frame;
  logic               miso_nxt, rx_valid_nxt, frame_err_nxt, rx_upd;
  logic               tx_head;

  spi_shifter #(.W(FRAME_W), .MSB_FIRST(MSB_FIRST)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .ser_in  (MOSI),
    .par_in  (sh_par_in),
    .par_out (sh_q),
    .ser_out (sh_ser_out)
  );

  // The first tx bit goes straight to MISO at capture, so the shifter is loaded one position ahead.
  assign tx_head   = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
  assign sh_par_in = MSB_FIRST ? {tx_data[DATA_W-2:0], 3'b000} : {3'b000, tx_data[DATA_W-1:1]};
  assign rx_frame  = MSB_FIRST ? {sh_q[FRAME_W-2:0], MOSI} : {MOSI, sh_q[FRAME_W-1:1]};

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    rd_addr_seen_nxt = rd_addr_seen;
    sh_load          = 1'b0;
    sh_shift         = 1'b0;
    miso_nxt         = 1'b0;
    rx_valid_nxt     = 1'b0;
    frame_err_nxt    = 1'b0;
    rx_upd           = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!SS_n) state_nxt = ST_CHK_CMD;
      end
      ST_CHK_CMD: begin
        cnt_nxt = '0;
        if (SS_n) begin
          state_nxt     = ST_IDLE;
          frame_err_nxt = 1'b1;
        end else if (!MOSI) begin
          state_nxt = ST_WRITE;
        end else if (rd_addr_seen) begin
          state_nxt = ST_READ_DATA;
        end else begin
          state_nxt = ST_READ_ADD;
        end
      end
      ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
        if (cnt == FRAME_LAST) begin
          // The last bit completes the frame even if SS_n rises on the same edge.
          sh_shift     = 1'b1;
          rx_upd       = 1'b1;
          rx_valid_nxt = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = ST_IDLE;
          if (state == ST_READ_ADD) rd_addr_seen_nxt = 1'b1;
          if (state == ST_READ_DATA) begin
            rd_addr_seen_nxt = 1'b0;
            if (!SS_n) state_nxt = ST_TX_WAIT;
          end
        end else if (SS_n) begin
          state_nxt     = ST_IDLE;
          frame_err_nxt = 1'b1;
        end else begin
          sh_shift = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      ST_TX_WAIT: begin
        cnt_nxt = '0;
        if (SS_n) begin
          state_nxt     = ST_IDLE;
          frame_err_nxt = 1'b1;
        end else if (tx_valid) begin
          sh_load   = 1'b1;
          miso_nxt  = tx_head;
          state_nxt = ST_TX_SHIFT;
        end
      end
      ST_TX_SHIFT: begin
        if (cnt == TX_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (SS_n) begin
          state_nxt     = ST_IDLE;
          frame_err_nxt = 1'b1;
          cnt_nxt       = '0;
        end else begin
          miso_nxt = sh_ser_out;
          sh_shift = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rd_addr_seen <= 1'b0;
      MISO         <= 1'b0;
      tx_ready     <= 1'b0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rx_data      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rd_addr_seen <= rd_addr_seen_nxt;
      MISO         <= miso_nxt;
      tx_ready     <= (state_nxt == ST_TX_WAIT);
      rx_valid     <= rx_valid_nxt;
      frame_err    <= frame_err_nxt;
      if (rx_upd) rx_data <= rx_frame;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised frame-level bench for spi_slave_param with an expectation model per clock.
module tb_spi_slave_param;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = DW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ss_n, mosi, tx_valid;
  logic [DW-1:0] tx_data;
  logic          miso, tx_ready, rx_valid, frame_err;
  logic [FW-1:0] rx_data;

  logic          ss_b, mosi_b;
  logic [7:0]    tx_data_b;
  logic          miso_b, tx_ready_b, rx_valid_b, frame_err_b;
  logic [9:0]    rx_data_b;

  logic          ss_c, mosi_c;
  logic [15:0]   tx_data_c;
  logic          miso_c, tx_ready_c, rx_valid_c, frame_err_c;
  logic [17:0]   rx_data_c;

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .tx_valid(tx_valid), .tx_data(tx_data),
    .MISO(miso), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err));

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .SS_n(ss_b), .MOSI(mosi_b), .tx_valid(1'b0), .tx_data(tx_data_b),
    .MISO(miso_b), .tx_ready(tx_ready_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b), .frame_err(frame_err_b));

  spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b1)) dut_w16 (
    .clk(clk), .rst(rst), .SS_n(ss_c), .MOSI(mosi_c), .tx_valid(1'b0), .tx_data(tx_data_c),
    .MISO(miso_c), .tx_ready(tx_ready_c), .rx_valid(rx_valid_c), .rx_data(rx_data_c), .frame_err(frame_err_c));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: last completed frame and whether a read address has been seen.
  logic [FW-1:0] m_rxd  = '0;
  bit            m_seen = 1'b0;

  // Expected outputs after the most recent clock edge.
  logic          e_miso = 1'b0, e_txr = 1'b0, e_rxv = 1'b0, e_ferr = 1'b0;
  logic [FW-1:0] e_rxd  = '0;
  bit            chk_en = 1'b0;
  logic [DW-1:0] miso_hist = '0;
  logic [DW-1:0] last_tx   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Compare the main DUT against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("MISO",      32'(miso),      32'(e_miso));
      check("tx_ready",  32'(tx_ready),  32'(e_txr));
      check("rx_valid",  32'(rx_valid),  32'(e_rxv));
      check("frame_err", 32'(frame_err), 32'(e_ferr));
      check("rx_data",   32'(rx_data),   32'(e_rxd));
      miso_hist = {miso_hist[DW-2:0], miso};
    end
  end

  // Apply one cycle of inputs and record the outputs expected after that edge.
  task automatic drive(input logic ss, input logic mi, input logic tv, input logic [DW-1:0] td,
                       input logic xmiso, input logic xtxr, input logic xrxv, input logic xferr);
    ss_n = ss; mosi = mi; tx_valid = tv; tx_data = td;
    @(posedge clk); #1;
    e_miso = xmiso; e_txr = xtxr; e_rxv = xrxv; e_ferr = xferr; e_rxd = m_rxd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One transaction: abort_at -1 aborts at command select, 0..FW-2 after that many bits, -2 never.
  task automatic frame(input bit cmd, input logic [FW-1:0] v, input int abort_at, input bit ss_last,
                       input int n_wait, input bit wait_abort, input logic [DW-1:0] td, input int tx_abort);
    bit is_rd_data;
    bit cont;
    is_rd_data = cmd && m_seen;
    cont = 1'b0;
    drive(1'b0, rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    if (abort_at == -1) begin
      drive(1'b1, cmd, rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    drive(1'b0, cmd, rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(FW); i++) begin
      if (i == abort_at) begin
        drive(1'b1, v[FW-1-i], rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      if (i == int'(FW) - 1) begin
        m_rxd = v;
        if (is_rd_data) m_seen = 1'b0;
        else if (cmd) m_seen = 1'b1;
        cont = is_rd_data && !ss_last;
        drive(ss_last, v[FW-1-i], rb(), DW'($urandom), 1'b0, cont, 1'b1, 1'b0);
      end else begin
        drive(1'b0, v[FW-1-i], rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    if (!cont) return;
    for (int i = 0; i < n_wait; i++) drive(1'b0, rb(), 1'b0, DW'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
    if (wait_abort) begin
      drive(1'b1, rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    drive(1'b0, rb(), 1'b1, td, td[DW-1], 1'b0, 1'b0, 1'b0);
    for (int j = 1; j < int'(DW); j++) begin
      if (j == tx_abort) begin
        drive(1'b1, rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      drive(1'b0, rb(), rb(), DW'($urandom), td[DW-1-j], 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); #1;
    last_tx = miso_hist;
    drive(rb(), rb(), rb(), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [9:0]  vb [2];
  logic [17:0] vc;

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    ss_b = 1'b1; mosi_b = 1'b0; tx_data_b = '0;
    ss_c = 1'b1; mosi_c = 1'b0; tx_data_c = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_MISO",      32'(miso),      32'd0);
    check("reset_rx_valid",  32'(rx_valid),  32'd0);
    check("reset_rx_data",   32'(rx_data),   32'd0);
    check("reset_tx_ready",  32'(tx_ready),  32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    idle(2);

    // Directed write, read sequence and abort with pinned literal results.
    frame(1'b0, 10'h1A5, -2, 1'b0, 0, 1'b0, '0, 0);
    check("write_rx_data",  32'(rx_data),  32'h1A5);
    check("write_rx_valid", 32'(rx_valid), 32'd1);
    idle(1);
    check("write_rx_valid_clear", 32'(rx_valid), 32'd0);
    frame(1'b1, 10'h2C3, -2, 1'b0, 0, 1'b0, '0, 0);
    check("rd_addr_tx_ready", 32'(tx_ready), 32'd0);
    idle(2);
    frame(1'b1, 10'h300, -2, 1'b0, 2, 1'b0, 8'h96, 0);
    check("read_miso_bits", 32'(last_tx), 32'h96);
    check("read_done_miso", 32'(miso),    32'd0);
    idle(2);
    frame(1'b0, 10'h3FF, 5, 1'b0, 0, 1'b0, '0, 0);
    check("abort_frame_err", 32'(frame_err), 32'd1);
    check("abort_rx_valid",  32'(rx_valid),  32'd0);
    check("abort_rx_data",   32'(rx_data),   32'h300);
    idle(2);

    // Randomised transactions including aborts at every stage.
    for (int n = 0; n < 200; n++) begin
      int r, ab, tab;
      r   = int'($urandom_range(0, 9));
      ab  = (r == 0) ? int'($urandom_range(0, FW - 2)) : ((r == 1) ? -1 : -2);
      tab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, DW - 1)) : 0;
      frame(1'($urandom), FW'($urandom), ab, ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), DW'($urandom), tab);
      idle(int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a write frame.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, rb(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; m_rxd = '0; m_seen = 1'b0;
    drive(1'b0, rb(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("midreset_rx_data",   32'(rx_data),   32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    idle(2);
    frame(1'b1, FW'($urandom), -2, 1'b0, 0, 1'b0, DW'($urandom), 0);
    idle(2);

    // LSB-first instance; the last bit coincides with SS_n rising.
    vb[0] = 10'h001;
    vb[1] = 10'($urandom);
    for (int k = 0; k < 2; k++) begin
      ss_b = 1'b0; @(posedge clk); #1;
      mosi_b = 1'b0; @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
        mosi_b = vb[k][i];
        if (i == 9) ss_b = 1'b1;
        @(posedge clk); #1;
      end
      check("lsb_rx_data",   32'(rx_data_b),   32'(vb[k]));
      check("lsb_rx_valid",  32'(rx_valid_b),  32'd1);
      check("lsb_frame_err", 32'(frame_err_b), 32'd0);
      @(posedge clk); #1;
      check("lsb_rx_valid_clear", 32'(rx_valid_b), 32'd0);
      check("lsb_idle_outputs",   32'({miso_b, tx_ready_b}), 32'd0);
    end

    // 16-bit payload instance.
    vc = 18'h2ABCD;
    ss_c = 1'b0; @(posedge clk); #1;
    mosi_c = 1'b0; @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      mosi_c = vc[17-i];
      @(posedge clk); #1;
    end
    check("w16_rx_data",   32'(rx_data_c),   32'h2ABCD);
    check("w16_rx_valid",  32'(rx_valid_c),  32'd1);
    check("w16_frame_err", 32'(frame_err_c), 32'd0);
    ss_c = 1'b1;
    @(posedge clk); #1;
    check("w16_idle_outputs", 32'({miso_c, tx_ready_c, rx_valid_c}), 32'd0);

    idle(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
